// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: multi-cycle SRAM access sequencer that freezes the pipeline until a load/store completes
module mem_access_ctrl #(
  parameter int ADDR_BASE   = 1024,
  parameter int SRAM_AW     = 18,
  parameter int WAIT_CYCLES = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic               freeze,
  output logic               req_error,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [31:0]        sram_wdata,
  input  logic [31:0]        sram_rdata,
  output logic               sram_we_n,
  output logic               sram_oe_n
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t     state;
  logic [3:0] cnt;
  logic       wr;
  logic       req;
  assign req    = mem_read | mem_write;
  assign freeze = req & (state != DONE);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      wr         <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      sram_we_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      read_data  <= '0;
      ready      <= 1'b0;
      req_error  <= 1'b0;
    end else begin
      req_error <= req_error | (mem_read & mem_write);
      case (state)
        IDLE: if (req) begin
          sram_addr  <= SRAM_AW'((address - 32'(ADDR_BASE)) >> 2);
          sram_wdata <= write_data;
          wr         <= mem_write;
          sram_we_n  <= ~mem_write;
          sram_oe_n  <= mem_write;
          cnt        <= 4'(WAIT_CYCLES - 1);
          state      <= ACCESS;
        end
        ACCESS: if (cnt != 0) cnt <= cnt - 4'd1;
        else begin
          if (!wr) read_data <= sram_rdata;
          sram_we_n <= 1'b1;
          sram_oe_n <= 1'b1;
          ready     <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          ready <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: scoreboard bench for mem_access_ctrl with a behavioural SRAM
module tb_mem_access_ctrl;
  logic        clk = 0, rst = 1;
  logic        mem_read = 0, mem_write = 0;
  logic [31:0] address = 0, write_data = 0;
  logic [31:0] read_data, sram_wdata, sram_rdata = 0;
  logic        ready, freeze, req_error, sram_we_n, sram_oe_n;
  logic [17:0] sram_addr;

  mem_access_ctrl dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .address(address), .write_data(write_data), .read_data(read_data),
    .ready(ready), .freeze(freeze), .req_error(req_error),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [logic [17:0]];
  always @(posedge clk) if (!sram_we_n) mem[sram_addr] = sram_wdata;
  always @(negedge clk) sram_rdata = (!sram_oe_n && mem.exists(sram_addr)) ? mem[sram_addr] : 32'h0;

  typedef struct {
    logic        ld;
    logic [17:0] addr;
    logic [31:0] data;
    logic [31:0] wd;
    int          we;
    int          oe;
  } exp_t;
  exp_t q[$];
  int checks = 0, errs = 0;
  int fc = 0, wc = 0, oc = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rdmem(input logic [17:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      fc = 0; wc = 0; oc = 0;
    end else if (ready) begin
      chk("freeze_at_ready", 32'(freeze), 0);
      if (q.size() == 0) chk("unexpected_ready", 1, 0);
      else begin
        e = q.pop_front();
        chk("sram_addr", 32'(sram_addr), 32'(e.addr));
        chk("read_data", read_data, e.data);
        chk("freeze_cycles", fc, 6);
        chk("we_low_cycles", wc, e.we);
        chk("oe_low_cycles", oc, e.oe);
        if (!e.ld) chk("sram_wdata", sram_wdata, e.wd);
      end
      fc = 0; wc = 0; oc = 0;
    end else begin
      fc += int'(freeze); wc += int'(!sram_we_n); oc += int'(!sram_oe_n);
    end
  end

  task automatic issue(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [17:0] ea, input logic [31:0] ed);
    mem_read = rd; mem_write = wr; address = a; write_data = d;
    q.push_back('{ld: rd & !wr, addr: ea, data: ed, wd: d, we: wr ? 5 : 0, oe: wr ? 0 : 5});
  endtask

  task automatic wait_ready(input string n);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      seen = ready;
    end
    chk({n, "_ready_seen"}, 32'(seen), 1);
  endtask

  task automatic idle();
    mem_read = 0; mem_write = 0;
  endtask

  task automatic chk_reset(input string n);
    chk({n, "_we_n"}, 32'(sram_we_n), 1);
    chk({n, "_oe_n"}, 32'(sram_oe_n), 1);
    chk({n, "_ready"}, 32'(ready), 0);
    chk({n, "_read_data"}, read_data, 0);
    chk({n, "_req_error"}, 32'(req_error), 0);
    chk({n, "_sram_addr"}, 32'(sram_addr), 0);
    chk({n, "_sram_wdata"}, sram_wdata, 0);
    chk({n, "_freeze"}, 32'(freeze), 0);
  endtask

  initial begin
    #3 rst = 0;
    #1 chk_reset("por");
    repeat (2) @(posedge clk);
    #1 rst = 1;
    // store: word 1, read_data untouched
    @(posedge clk); #1;
    issue(0, 1, 32'd1028, 32'hDEADBEEF, 18'd1, 32'h0);
    wait_ready("store");
    idle();
    chk("store_mem1", rdmem(18'd1), 32'hDEADBEEF);
    // load back
    @(posedge clk); #1;
    issue(1, 0, 32'd1028, 32'h0, 18'd1, 32'hDEADBEEF);
    wait_ready("load");
    idle();
    // conflicting request at an address that wraps to word 0
    @(posedge clk); #1;
    issue(1, 1, 32'h0010_0400, 32'h12345678, 18'd0, 32'hDEADBEEF);
    wait_ready("conflict");
    idle();
    chk("conflict_req_error", 32'(req_error), 1);
    chk("conflict_mem0", rdmem(18'd0), 32'h12345678);
    // back-to-back, request held continuously
    @(posedge clk); #1;
    issue(1, 0, 32'd1024, 32'h0, 18'd0, 32'h12345678);
    wait_ready("b2b_load");
    issue(0, 1, 32'd1032, 32'hCAFEF00D, 18'd2, 32'h12345678);
    wait_ready("b2b_store");
    idle();
    chk("b2b_mem2", rdmem(18'd2), 32'hCAFEF00D);
    chk("req_error_sticky", 32'(req_error), 1);
    // abort in the 3rd access cycle of a store
    @(posedge clk); #1;
    mem_write = 1; address = 32'd1040; write_data = 32'h55AA55AA;
    repeat (3) @(posedge clk);
    #1 chk("abort_we_active", 32'(sram_we_n), 0);
    rst = 0;
    idle();
    #1 chk_reset("abort");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("abort_no_ready", 32'(ready), 0);
    end
    rst = 1;
    @(posedge clk); #1;
    issue(1, 0, 32'd1028, 32'h0, 18'd1, 32'hDEADBEEF);
    wait_ready("post_abort_load");
    idle();
    repeat (3) @(posedge clk);
    #1 chk("scoreboard_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Multi-cycle controller between the EXE/MEM pipeline register and an external single-port word SRAM.
- Takes the EXE-produced `mem_read`/`mem_write`, ALU result (byte address) and `reg2` (store data).
- Sequences one SRAM access of fixed latency and asserts `freeze` to stall the whole pipeline until the access completes.
- Sits in the MEM stage, replacing the single-cycle data memory.

Parameters:
- ADDR_BASE, 1024: byte address mapped to SRAM word 0.
- SRAM_AW, 18: SRAM word-address width.
- WAIT_CYCLES, 5: SRAM access latency in cycles, legal range 1..15.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-low reset
- mem_read  input  1  load request from EXE/MEM register
- mem_write  input  1  store request from EXE/MEM register
- address  input  32  byte address (ALU result)
- write_data  input  32  store data (reg2)
- read_data  output  32  load result, valid while `ready`=1
- ready  output  1  access complete this cycle; pipeline may advance
- freeze  output  1  stall all pipeline registers and PC
- req_error  output  1  sticky: `mem_read` and `mem_write` were seen together
- sram_addr  output  SRAM_AW  word address to SRAM
- sram_wdata  output  32  SRAM write data
- sram_rdata  input  32  SRAM read data
- sram_we_n  output  1  SRAM write enable, active-low
- sram_oe_n  output  1  SRAM output enable, active-low

Behaviour:
- **Reset values (rst=0, asynchronous):**
  - state=IDLE, counter=0.
  - sram_addr=0, sram_wdata=0, sram_we_n=1, sram_oe_n=1.
  - read_data=0, ready=0, req_error=0.
  - freeze follows its combinational equation (0 with no request).
- **Address mapping:** word = (address − ADDR_BASE) >> 2, truncated to SRAM_AW bits (modulo wrap, no range check). address[1:0] ignored.
- **Request:** req = mem_read | mem_write. If both are asserted, the write is performed and req_error is set (cleared only by reset).
- **State IDLE:**
  - With req=0: stay.
  - With req=1: at the clock edge, register sram_addr and sram_wdata, register the operation (wr = mem_write), load counter = WAIT_CYCLES−1, go to ACCESS.
- **State ACCESS:**
  - Drive sram_we_n = ~wr and sram_oe_n = wr, both from registered state.
  - Each cycle: if counter≠0, decrement.
  - If counter=0: when rd, capture sram_rdata into read_data; go to DONE.
- **State DONE:**
  - ready=1 for exactly one cycle; sram_we_n=1, sram_oe_n=1.
  - Go to IDLE unconditionally. The pipeline advances on this edge, so the request is consumed even if still asserted.
- **freeze = req & (state≠DONE)**, combinational. It is high in the IDLE cycle where the request first appears.
  - Stall per access = WAIT_CYCLES+1 cycles; total access time = WAIT_CYCLES+2 cycles including the DONE cycle.
- **Latched operands:** input changes during ACCESS are ignored.
- **read_data:** holds its value until the next load completes. Stores do not modify it.
- **Back-to-back requests:** IDLE is re-entered after DONE, so the next request sees one IDLE cycle with freeze=1 (no idle bubble beyond that).
- **Reset mid-access:** the access is aborted immediately. sram_we_n/oe_n go to 1 asynchronously and state returns to IDLE. A partial write to SRAM is acceptable.
- **WAIT_CYCLES=1:** ACCESS lasts one cycle (counter loaded with 0).

Test Plan:
1. **Reset:** rst=0 mid-run → all outputs at reset values within the same cycle; sram_we_n=1, sram_oe_n=1, state IDLE.
2. **Store:** mem_write=1, address=1028, write_data=0xDEADBEEF, WAIT_CYCLES=5 →
   - freeze=1 for 6 cycles.
   - sram_addr=1 and sram_we_n=0 for 5 cycles.
   - ready=1 and freeze=0 on the 7th cycle; sram_wdata=0xDEADBEEF throughout.
3. **Load:** mem_read=1, address=1028, SRAM model returns 0xDEADBEEF →
   - sram_oe_n=0 for 5 cycles, sram_we_n stays 1.
   - read_data=0xDEADBEEF when ready=1; freeze low that cycle.
4. **Back-to-back:** load at 1024 then store at 1032, requests held continuously →
   - two complete sequences with one ready pulse each.
   - second sram_addr=2, no lost or duplicated access.
5. **Conflict and wrap:** mem_read=mem_write=1, address=1024+4·2^18 →
   - write performed at sram_addr=0.
   - req_error=1 and stays 1 until reset.
6. **Abort:** rst pulsed low in the 3rd ACCESS cycle of a store →
   - sram_we_n=1 immediately, ready never pulses.
   - after release, a new load completes normally.
